// File: rtl/hart_state_unit.sv
// hart_state_unit
//   Tracks which of the four harts are active, reserved (spawn in flight) or
//   primary. A spawn allocates the lowest-index free hart, reserves it, and
//   offers its start PC to IF until IF acknowledges, at which point the hart
//   becomes active. Kills deactivate a hart; the last active hart can never be
//   killed. Set-primary moves the primary marker to an active hart.
//
// Ports
//   clk, rst                        clock, synchronous active-high reset
//   id_hstart / id_hstart_pc        spawn request and start PC
//   id_hkill / id_set_hid           kill request and target hart
//   id_hprim / id_prim_hid          set-primary request and target hart
//   if_start_ack                    IF has consumed the pending start PC
//   hstart_ack / hstart_hid         registered spawn-accepted pulse, allocated hart
//   hstart_busy                     combinational spawn refusal
//   if_start_valid/_hid/_pc         pending start toward IF
//   prim_hstate, acti_hstate        one-hot primary, active bitmap
//   acti_num                        popcount of acti_hstate
//   hkill_err                       registered kill-refused pulse
module hart_state_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_hstart,
    input  logic [31:0] id_hstart_pc,
    input  logic        id_hkill,
    input  logic [1:0]  id_set_hid,
    input  logic        id_hprim,
    input  logic [1:0]  id_prim_hid,
    input  logic        if_start_ack,
    output logic        hstart_ack,
    output logic [1:0]  hstart_hid,
    output logic        hstart_busy,
    output logic        if_start_valid,
    output logic [1:0]  if_start_hid,
    output logic [31:0] if_start_pc,
    output logic [3:0]  prim_hstate,
    output logic [3:0]  acti_hstate,
    output logic [2:0]  acti_num,
    output logic        hkill_err
);

    typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [3:0]  rsv_q, rsv_d;
    logic [3:0]  acti_q, acti_d;
    logic [3:0]  prim_q, prim_d;
    logic [2:0]  num_q, num_d;
    logic        ack_q, ack_d;
    logic [1:0]  hid_q, hid_d;
    logic [1:0]  shid_q, shid_d;
    logic [31:0] spc_q, spc_d;
    logic        kerr_q, kerr_d;

    logic [3:0]  free;
    logic [1:0]  alloc;
    logic        spawn_ok, start_done, kill_ok;

    function automatic logic [1:0] lowest_idx(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    always_comb begin
        state_d = state_q;
        rsv_d   = rsv_q;
        acti_d  = acti_q;
        prim_d  = prim_q;
        ack_d   = 1'b0;
        hid_d   = hid_q;
        shid_d  = shid_q;
        spc_d   = spc_q;
        kerr_d  = 1'b0;

        // Free set is taken from registered state only, so a hart killed this
        // cycle cannot be handed to a same-cycle spawn.
        free        = ~acti_q & ~rsv_q;
        alloc       = lowest_idx(free);
        hstart_busy = id_hstart && (state_q == PEND || free == 4'b0000);
        spawn_ok    = id_hstart && state_q == IDLE && free != 4'b0000;
        start_done  = state_q == PEND && if_start_ack;
        // Sole-active check uses the pre-ack count; a reserved hart is never
        // active, so killing it falls into the error path.
        kill_ok     = id_hkill && acti_q[id_set_hid] && num_q >= 3'd2;

        if (spawn_ok) begin
            state_d       = PEND;
            rsv_d[alloc]  = 1'b1;
            ack_d         = 1'b1;
            hid_d         = alloc;
            shid_d        = alloc;
            spc_d         = id_hstart_pc;
        end
        if (start_done) begin
            state_d        = IDLE;
            rsv_d[shid_q]  = 1'b0;
            acti_d[shid_q] = 1'b1;
        end

        if (kill_ok) acti_d[id_set_hid] = 1'b0;
        else if (id_hkill) kerr_d = 1'b1;

        // Killed primary falls back to the lowest remaining active hart; an
        // explicit set-primary to a surviving active hart overrides that.
        if (kill_ok && prim_q[id_set_hid])
            prim_d = acti_d & (~acti_d + 4'd1);
        if (id_hprim && acti_q[id_prim_hid] && !(kill_ok && id_set_hid == id_prim_hid))
            prim_d = 4'b0001 << id_prim_hid;

        num_d = {2'b00, acti_d[0]} + {2'b00, acti_d[1]}
              + {2'b00, acti_d[2]} + {2'b00, acti_d[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rsv_q   <= 4'b0000;
            acti_q  <= 4'b0001;
            prim_q  <= 4'b0001;
            num_q   <= 3'd1;
            ack_q   <= 1'b0;
            hid_q   <= 2'd0;
            shid_q  <= 2'd0;
            spc_q   <= 32'd0;
            kerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rsv_q   <= rsv_d;
            acti_q  <= acti_d;
            prim_q  <= prim_d;
            num_q   <= num_d;
            ack_q   <= ack_d;
            hid_q   <= hid_d;
            shid_q  <= shid_d;
            spc_q   <= spc_d;
            kerr_q  <= kerr_d;
        end
    end

    assign hstart_ack     = ack_q;
    assign hstart_hid     = hid_q;
    assign if_start_valid = (state_q == PEND);
    assign if_start_hid   = shid_q;
    assign if_start_pc    = spc_q;
    assign prim_hstate    = prim_q;
    assign acti_hstate    = acti_q;
    assign acti_num       = num_q;
    assign hkill_err      = kerr_q;

endmodule
